// File: rtl/car_alarm_siren_controller.sv
// rtl/car_alarm_siren_controller.sv - arm/debounce/entry-delay/siren sequencer for the car alarm condition
// Optional macro ALARM_EVENT_COUNT_EN adds the saturating AlarmEventCount output.
module car_alarm_siren_controller #(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int ENTRY_DELAY_CYCLES = 10,
  parameter int SIREN_CYCLES       = 20,
  parameter int PULSE_HALF_PERIOD  = 3,
  parameter int CNT_W              = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       CarAlarmSignal,
  input  logic       ArmRequest,
  input  logic       DisarmRequest,
  output logic       SirenOn,
  output logic       HornPulse,
  output logic       ArmedStatus,
  output logic [2:0] AlarmState
`ifdef ALARM_EVENT_COUNT_EN
  ,
  output logic [7:0] AlarmEventCount
`endif
);

  typedef enum logic [2:0] {
    ST_DISARMED    = 3'd0,
    ST_ARMED       = 3'd1,
    ST_ENTRY_DELAY = 3'd2,
    ST_SOUNDING    = 3'd3,
    ST_COOLDOWN    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] W_ZERO       = '0;
  localparam logic [CNT_W-1:0] W_ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] W_DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_ENTRY_LOAD = CNT_W'(ENTRY_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_SIREN_LOAD = CNT_W'(SIREN_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_PULSE_LOAD = CNT_W'(PULSE_HALF_PERIOD - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_deb;
  logic [CNT_W-1:0] r_pulse_cnt;
  logic             r_siren;
  logic             r_horn;
  logic             r_armed;
`ifdef ALARM_EVENT_COUNT_EN
  logic [7:0]       r_event_cnt;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_DISARMED;
      r_cnt       <= W_ZERO;
      r_deb       <= W_ZERO;
      r_pulse_cnt <= W_ZERO;
      r_siren     <= 1'b0;
      r_horn      <= 1'b0;
      r_armed     <= 1'b0;
`ifdef ALARM_EVENT_COUNT_EN
      r_event_cnt <= 8'd0;
`endif
    end else if (DisarmRequest) begin
      // Disarm never touches the event counter; only reset clears it.
      r_state     <= ST_DISARMED;
      r_cnt       <= W_ZERO;
      r_deb       <= W_ZERO;
      r_pulse_cnt <= W_ZERO;
      r_siren     <= 1'b0;
      r_horn      <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      case (r_state)
        ST_DISARMED: begin
          if (ArmRequest) begin
            r_state <= ST_ARMED;
            r_deb   <= W_ZERO;
            r_armed <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (!CarAlarmSignal) begin
            r_deb <= W_ZERO;
          end else if (r_deb == W_DEB_LAST) begin
            r_state <= ST_ENTRY_DELAY;
            r_cnt   <= W_ENTRY_LOAD;
            r_deb   <= W_ZERO;
          end else begin
            r_deb <= r_deb + W_ONE;
          end
        end
        ST_ENTRY_DELAY: begin
          if (r_cnt == W_ZERO) begin
            r_state     <= ST_SOUNDING;
            r_cnt       <= W_SIREN_LOAD;
            r_pulse_cnt <= W_PULSE_LOAD;
            r_siren     <= 1'b1;
            r_horn      <= 1'b1;
`ifdef ALARM_EVENT_COUNT_EN
            if (r_event_cnt != 8'hFF) r_event_cnt <= r_event_cnt + 8'd1;
`endif
          end else begin
            r_cnt <= r_cnt - W_ONE;
          end
        end
        ST_SOUNDING: begin
          if (r_cnt == W_ZERO) begin
            r_state     <= ST_COOLDOWN;
            r_pulse_cnt <= W_ZERO;
            r_siren     <= 1'b0;
            r_horn      <= 1'b0;
          end else begin
            r_cnt <= r_cnt - W_ONE;
            if (r_pulse_cnt == W_ZERO) begin
              r_horn      <= ~r_horn;
              r_pulse_cnt <= W_PULSE_LOAD;
            end else begin
              r_pulse_cnt <= r_pulse_cnt - W_ONE;
            end
          end
        end
        ST_COOLDOWN: begin
          // Wait for the condition to clear so a stuck input cannot retrigger at once.
          if (!CarAlarmSignal) begin
            r_state <= ST_ARMED;
            r_deb   <= W_ZERO;
          end
        end
        default: begin
          r_state <= ST_DISARMED;
          r_cnt   <= W_ZERO;
          r_deb   <= W_ZERO;
          r_siren <= 1'b0;
          r_horn  <= 1'b0;
          r_armed <= 1'b0;
        end
      endcase
    end
  end

  assign SirenOn     = r_siren;
  assign HornPulse   = r_horn;
  assign ArmedStatus = r_armed;
  assign AlarmState  = r_state;
`ifdef ALARM_EVENT_COUNT_EN
  assign AlarmEventCount = r_event_cnt;
`endif

endmodule

// File: tb/tb_car_alarm_siren_controller.sv
// tb/tb_car_alarm_siren_controller.sv - directed plus random bench against a cycle-age reference model
module tb_car_alarm_siren_controller;

  localparam int D = 4;
  localparam int E = 10;
  localparam int S = 20;
  localparam int P = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       CarAlarmSignal = 1'b0;
  logic       ArmRequest = 1'b0;
  logic       DisarmRequest = 1'b0;
  logic       SirenOn;
  logic       HornPulse;
  logic       ArmedStatus;
  logic [2:0] AlarmState;
`ifdef ALARM_EVENT_COUNT_EN
  logic [7:0] AlarmEventCount;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: state name, cycles elapsed in that state, consecutive high samples while armed.
  int m_state = 0;
  int m_age   = 0;
  int m_run   = 0;
  int m_ev    = 0;

  always #5 clk = ~clk;

  car_alarm_siren_controller #(
    .DEBOUNCE_CYCLES(D), .ENTRY_DELAY_CYCLES(E), .SIREN_CYCLES(S),
    .PULSE_HALF_PERIOD(P), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .CarAlarmSignal(CarAlarmSignal),
    .ArmRequest(ArmRequest), .DisarmRequest(DisarmRequest),
    .SirenOn(SirenOn), .HornPulse(HornPulse), .ArmedStatus(ArmedStatus),
    .AlarmState(AlarmState)
`ifdef ALARM_EVENT_COUNT_EN
    , .AlarmEventCount(AlarmEventCount)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic arm, input logic dis, input logic sig);
    if (!rst) begin
      m_state = 0; m_age = 0; m_run = 0; m_ev = 0;
    end else if (dis) begin
      m_state = 0; m_age = 0; m_run = 0;
    end else begin
      case (m_state)
        0: if (arm) begin m_state = 1; m_run = 0; end
        1: begin
          m_run = sig ? m_run + 1 : 0;
          if (m_run == D) begin m_state = 2; m_age = 0; m_run = 0; end
        end
        2: begin
          m_age++;
          if (m_age == E) begin m_state = 3; m_age = 0; if (m_ev < 255) m_ev++; end
        end
        3: begin
          m_age++;
          if (m_age == S) begin m_state = 4; m_age = 0; end
        end
        default: if (!sig) begin m_state = 1; m_run = 0; end
      endcase
    end
  endtask

  task automatic check_outputs();
    logic exp_horn;
    exp_horn = (m_state == 3) && (((m_age / P) % 2) == 0);
    chk("AlarmState", 16'(AlarmState), 16'(m_state));
    chk("ArmedStatus", 16'(ArmedStatus), 16'(m_state != 0));
    chk("SirenOn", 16'(SirenOn), 16'(m_state == 3));
    chk("HornPulse", 16'(HornPulse), 16'(exp_horn));
`ifdef ALARM_EVENT_COUNT_EN
    chk("AlarmEventCount", 16'(AlarmEventCount), 16'(m_ev));
`endif
  endtask

  // Inputs change on the falling edge; outputs are checked one falling edge after the rising edge.
  task automatic cyc(input logic rst, input logic arm, input logic dis, input logic sig);
    reset_n = rst; ArmRequest = arm; DisarmRequest = dis; CarAlarmSignal = sig;
    @(posedge clk);
    model_step(rst, arm, dis, sig);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run_sig(input int n, input logic sig);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, sig);
  endtask

  initial begin
    int siren_cycles;
    int entry_cycles;
    int hold;
    logic sig;
    @(negedge clk);

    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    chk("reset_state", 16'(AlarmState), 16'd0);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("arm_latency", 16'(ArmedStatus), 16'd1);

    run_sig(3, 1'b1);
    run_sig(1, 1'b0);
    chk("glitch_rejected", 16'(AlarmState), 16'd1);
    run_sig(3, 1'b1);
    chk("debounce_pending", 16'(AlarmState), 16'd1);
    run_sig(1, 1'b1);
    chk("trigger_after_4th", 16'(AlarmState), 16'd2);

    entry_cycles = 1;
    siren_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      if (AlarmState == 3'd2) entry_cycles++;
      if (SirenOn) siren_cycles++;
    end
    chk("entry_len", 16'(entry_cycles), 16'(E));
    chk("siren_len", 16'(siren_cycles), 16'(S));
    chk("cooldown_hold", 16'(AlarmState), 16'd4);
    run_sig(1, 1'b0);
    chk("cooldown_exit", 16'(AlarmState), 16'd1);

    run_sig(D, 1'b1);
    run_sig(4, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("disarm_entry", 16'(AlarmState), 16'd0);

    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("arm_and_disarm", 16'(ArmedStatus), 16'd0);

    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    run_sig(D + E + 2, 1'b1);
    chk("in_sounding", 16'(SirenOn), 16'd1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    chk("disarm_siren", 16'(SirenOn), 16'd0);
    chk("disarm_horn", 16'(HornPulse), 16'd0);

    sig = 1'b0;
    hold = 0;
    for (int i = 0; i < 4000; i++) begin
      if (hold == 0) begin
        sig = 1'($urandom_range(0, 1));
        hold = sig ? $urandom_range(1, 40) : $urandom_range(1, 6);
      end
      hold--;
      cyc(($urandom_range(0, 299) != 0), ($urandom_range(0, 5) == 0),
          ($urandom_range(0, 79) == 0), sig);
    end

`ifdef ALARM_EVENT_COUNT_EN
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 257; k++) begin
      run_sig(D + E + S + 1, 1'b1);
      run_sig(1, 1'b0);
    end
    chk("event_saturate", 16'(AlarmEventCount), 16'd255);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    chk("disarm_keeps_count", 16'(AlarmEventCount), 16'd255);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    run_sig(D + E + 5, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_mid_sounding", 16'(AlarmEventCount), 16'd0);
    chk("reset_siren", 16'(SirenOn), 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/car_alarm_siren_controller.md
# car_alarm_siren_controller

Sequential responder for the car alarm condition signal produced by the alarm condition logic (lights/door/ignition decode). Arms and disarms on request and debounces the alarm condition. Applies an entry delay during which the owner can disarm, then drives the siren and a pulsed horn for a bounded time. Sits between the alarm condition output and the vehicle siren/horn drivers.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 4: consecutive high samples of CarAlarmSignal required to trigger (≥1).
- ENTRY_DELAY_CYCLES, 10: cycles spent in ENTRY_DELAY before sounding (≥1).
- SIREN_CYCLES, 20: cycles spent in SOUNDING (≥1).
- PULSE_HALF_PERIOD, 3: HornPulse toggle interval in cycles (≥1).
- CNT_W, 16: width of the shared down-counter; every cycle parameter must be < 2^CNT_W.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- CarAlarmSignal  in  1  alarm condition from the condition logic; active high.
- ArmRequest  in  1  single-cycle-or-longer arm request; level sampled each clk.
- DisarmRequest  in  1  disarm request; level sampled each clk; priority over everything but reset.
- SirenOn  out  1  high in SOUNDING.
- HornPulse  out  1  pulsed horn, valid only in SOUNDING, else 0.
- ArmedStatus  out  1  high in every state except DISARMED.
- AlarmState  out  3  current state encoding: DISARMED=0, ARMED=1, ENTRY_DELAY=2, SOUNDING=3, COOLDOWN=4.
- AlarmEventCount  out  8  present only with ALARM_EVENT_COUNT_EN (see Configuration).

## Operation
- Moore FSM; all outputs decode from registered state and registers. No combinational input-to-output paths.
- DISARMED: ArmRequest=1 and DisarmRequest=0 -> ARMED. Debounce count is cleared on entry.
- ARMED: the debounce counter increments while CarAlarmSignal=1 and clears to 0 on any sample of 0. When CarAlarmSignal=1 is sampled with the count at DEBOUNCE_CYCLES-1, the FSM moves to ENTRY_DELAY and the down-counter loads ENTRY_DELAY_CYCLES-1.
- ENTRY_DELAY: decrements the counter each cycle. At 0 -> SOUNDING, counter loads SIREN_CYCLES-1, HornPulse register set to 1, and the pulse counter loads PULSE_HALF_PERIOD-1. CarAlarmSignal is ignored here, and dropping it does not cancel.
- SOUNDING: SirenOn=1. HornPulse inverts each time the pulse counter reaches 0, then the pulse counter reloads. At main counter 0 -> COOLDOWN.
- COOLDOWN: stays until CarAlarmSignal is sampled 0, then -> ARMED with the debounce count cleared. This prevents immediate retrigger on a persistent condition.
- DisarmRequest=1 in any state -> DISARMED next cycle, and all counters clear. If ArmRequest and DisarmRequest are both high, disarm wins.
- ArmRequest outside DISARMED is ignored.

## Timing
- Reset (reset_n=0 at an edge): state DISARMED. SirenOn=0, HornPulse=0, ArmedStatus=0, AlarmState=0, all counters 0, AlarmEventCount=0. Reset takes effect mid-sequence from any state.
- Arm latency: ArmRequest sampled at edge N gives ArmedStatus=1 after edge N.
- Trigger latency: CarAlarmSignal high for edges N..N+DEBOUNCE_CYCLES-1 gives ENTRY_DELAY after edge N+DEBOUNCE_CYCLES-1.
- ENTRY_DELAY lasts exactly ENTRY_DELAY_CYCLES cycles.
- SOUNDING lasts exactly SIREN_CYCLES cycles.
- HornPulse is 1 for the first PULSE_HALF_PERIOD SOUNDING cycles, then alternates with the same half period. It is forced to 0 on leaving SOUNDING.
- Disarm latency: 1 cycle from sampled DisarmRequest to SirenOn=0 and ArmedStatus=0.
- Counter boundaries: a parameter value of 1 gives a 1-cycle state. Counters never underflow because every reload happens at 0.

## Configuration
- ALARM_EVENT_COUNT_EN defined: AlarmEventCount port and register exist.
  - Increments by 1 on each ENTRY_DELAY->SOUNDING transition.
  - Saturates at 255.
  - Cleared only by reset; disarm does not clear it.
- ALARM_EVENT_COUNT_EN undefined: port and register absent. All other behaviour is identical.

## Test plan
- Reset then arm: reset_n=0 for 2 cycles, ArmRequest=1 for 1 cycle -> AlarmState=1 and ArmedStatus=1 one cycle later, SirenOn=0.
- Glitch rejection: armed, CarAlarmSignal high 3 cycles then low -> state stays ARMED. A following 4-cycle high -> ENTRY_DELAY after the 4th sample.
- Full sequence with defaults:
  - Trigger -> ENTRY_DELAY for 10 cycles, then SOUNDING for 20 cycles.
  - HornPulse pattern 111000111000… over the 20 SOUNDING cycles.
  - Then COOLDOWN while CarAlarmSignal=1. Signal drop -> ARMED.
- Disarm during ENTRY_DELAY cycle 5 -> DISARMED next cycle, SirenOn never asserted, AlarmEventCount unchanged.
- Simultaneous ArmRequest=1 and DisarmRequest=1 in DISARMED -> stays DISARMED. Disarm during SOUNDING -> SirenOn=0 and HornPulse=0 next cycle.
- Event count (macro defined): 257 full trigger/sound/cooldown sequences -> AlarmEventCount=255. Reset mid-SOUNDING -> all outputs 0 and count 0.
